data_mem_port_arbiter: RTL and testbench

Parametrised N-port arbiter for the single-ported data memory bus, sitting between the CPU's memory requesters (FP64 sequencer, AMO unit, EX load/store path, and future ports such as a debug/DMA master) and the L0 cache / data memory. It selects one request per cycle by fixed-priority or round-robin policy. It holds the bus for multi-beat locked transactions such as FP64 low/high words and AMO read-then-write. It routes fixed-latency read data back to the issuing port through a tag pipeline.

---
 rtl/data_mem_arb_pkg.sv | 34 +++
 rtl/rr_priority_picker.sv | 32 +++
 rtl/data_mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the data memory port arbiter.
package data_mem_arb_pkg;

    localparam int unsigned ARB_XLEN  = 32;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned MAX_IDX_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ARB_XLEN-1:0] addr;
        logic [ARB_XLEN-1:0] wdata;
        logic [BE_W-1:0]     byte_en;
        logic                read;
        logic                lock;
    } mem_req_t;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } rsp_tag_t;

    // (a + b) mod n for operands already below n.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// First set request at or after a base index, wrapping; base=0 gives fixed priority.
module rr_priority_picker
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_base,
    output logic [NUM_PORTS-1:0] o_grant_c,
    output logic [IDX_W-1:0]     o_idx_c,
    output logic                 o_any_c
);

    logic [IDX_W-1:0] cand_c;

    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        cand_c    = '0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            cand_c = IDX_W'(wrap_add(32'(i_base), off, NUM_PORTS));
            if (!o_any_c && i_req[cand_c]) begin
                o_any_c           = 1'b1;
                o_idx_c           = cand_c;
                o_grant_c[cand_c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_port_arbiter.sv
// N-port arbiter for the single-ported data memory bus with bus locking
// and a tag pipeline that steers fixed-latency read data back to its requester.
module data_mem_port_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned XLEN         = ARB_XLEN,
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned ROUND_ROBIN  = 0,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_PORTS-1:0]                i_req_valid,
    input  logic [NUM_PORTS-1:0][XLEN-1:0]      i_req_addr,
    input  logic [NUM_PORTS-1:0][XLEN-1:0]      i_req_wdata,
    input  logic [NUM_PORTS-1:0][3:0]           i_req_byte_en,
    input  logic [NUM_PORTS-1:0]                i_req_read,
    input  logic [NUM_PORTS-1:0]                i_req_lock,
    output logic [NUM_PORTS-1:0]                o_req_ready,
    input  logic                                i_stall,
    output logic [XLEN-1:0]                     o_data_mem_addr,
    output logic [XLEN-1:0]                     o_data_mem_wr_data,
    output logic [3:0]                          o_data_mem_per_byte_wr_en,
    output logic                                o_data_mem_read_enable,
    input  logic [XLEN-1:0]                     i_data_mem_rd_data,
    output logic [NUM_PORTS-1:0]                o_rsp_valid,
    output logic [XLEN-1:0]                     o_rsp_data,
    output logic                                o_lock_active,
    output logic [$clog2(NUM_PORTS)-1:0]        o_lock_owner
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    localparam int unsigned LAST  = READ_LATENCY - 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    rsp_tag_t         rsp_pipe_q [READ_LATENCY];
    rsp_tag_t         rsp_pipe_d [READ_LATENCY];

    logic [NUM_PORTS-1:0] owner_mask_c;
    logic [NUM_PORTS-1:0] elig_c;
    logic [NUM_PORTS-1:0] grant_c;
    logic [IDX_W-1:0]     base_c;
    logic [IDX_W-1:0]     win_idx_c;
    logic                 win_any_c;
    logic                 accept_c;
    logic                 rd_fire_c;
    mem_req_t             win_req_c;

    // While locked only the owner may compete.
    always_comb begin
        owner_mask_c          = '0;
        owner_mask_c[owner_q] = 1'b1;
        elig_c = (state_q == LOCKED) ? (i_req_valid & owner_mask_c) : i_req_valid;
        base_c = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;
    end

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_req     (elig_c),
        .i_base    (base_c),
        .o_grant_c (grant_c),
        .o_idx_c   (win_idx_c),
        .o_any_c   (win_any_c)
    );

    // Winner mux; bus enables are held off while reset is asserted.
    always_comb begin
        win_req_c = '0;
        if (win_any_c) begin
            win_req_c.addr    = i_req_addr[win_idx_c];
            win_req_c.wdata   = i_req_wdata[win_idx_c];
            win_req_c.byte_en = i_req_byte_en[win_idx_c];
            win_req_c.read    = i_req_read[win_idx_c];
            win_req_c.lock    = i_req_lock[win_idx_c];
        end
        accept_c  = win_any_c & ~i_stall & i_rst_n;
        rd_fire_c = accept_c & win_req_c.read & (win_req_c.byte_en == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Rotation advances only when a transaction ends (unlocked accept).
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept_c) begin
            if (win_req_c.lock) begin
                state_d = LOCKED;
                owner_d = win_idx_c;
            end else begin
                state_d = IDLE;
                owner_d = '0;
                if (ROUND_ROBIN != 0) begin
                    rr_ptr_d = IDX_W'(wrap_add(32'(win_idx_c), 1, NUM_PORTS));
                end
            end
        end
    end

    always_comb begin
        o_req_ready               = accept_c ? grant_c : '0;
        o_data_mem_addr           = win_req_c.addr;
        o_data_mem_wr_data        = win_req_c.wdata;
        o_data_mem_per_byte_wr_en = accept_c ? win_req_c.byte_en : '0;
        o_data_mem_read_enable    = rd_fire_c;
        o_lock_active             = (state_q == LOCKED);
        o_lock_owner              = owner_q;
        o_rsp_data                = i_data_mem_rd_data;
        o_rsp_valid               = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            o_rsp_valid[p] = rsp_pipe_q[LAST].valid && (rsp_pipe_q[LAST].idx == MAX_IDX_W'(p));
        end
    end

    // Response tag pipeline shifts every cycle, independent of stall.
    always_comb begin
        rsp_pipe_d[0].valid = rd_fire_c;
        rsp_pipe_d[0].idx   = MAX_IDX_W'(win_idx_c);
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            rsp_pipe_d[i] = rsp_pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                rsp_pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                rsp_pipe_q[i] <= rsp_pipe_d[i];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_port_arbiter.sv
// Directed bench: fixed, round-robin and two-cycle-latency arbiter instances on shared stimulus.
module tb_data_mem_port_arbiter;

    logic              clk;
    logic              rst_n;
    logic [3:0]        valid, read, lock;
    logic [3:0][31:0]  addr, wdata;
    logic [3:0][3:0]   be;
    logic              stall;
    logic [31:0]       rd_data;

    logic [3:0]  rdy_f, rspv_f, mbe_f;
    logic [31:0] maddr_f, mwd_f, rspd_f;
    logic        mre_f, lka_f;
    logic [1:0]  lko_f;

    logic [3:0]  rdy_r, rspv_r, mbe_r;
    logic [31:0] maddr_r, mwd_r, rspd_r;
    logic        mre_r, lka_r;
    logic [1:0]  lko_r;

    logic [3:0]  rdy_l, rspv_l, mbe_l;
    logic [31:0] maddr_l, mwd_l, rspd_l;
    logic        mre_l, lka_l;
    logic [1:0]  lko_l;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_port_arbiter #(.NUM_PORTS(4), .ROUND_ROBIN(0), .READ_LATENCY(1)) u_fix (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_addr(addr),
        .i_req_wdata(wdata), .i_req_byte_en(be), .i_req_read(read), .i_req_lock(lock),
        .o_req_ready(rdy_f), .i_stall(stall), .o_data_mem_addr(maddr_f),
        .o_data_mem_wr_data(mwd_f), .o_data_mem_per_byte_wr_en(mbe_f),
        .o_data_mem_read_enable(mre_f), .i_data_mem_rd_data(rd_data),
        .o_rsp_valid(rspv_f), .o_rsp_data(rspd_f), .o_lock_active(lka_f), .o_lock_owner(lko_f));

    data_mem_port_arbiter #(.NUM_PORTS(4), .ROUND_ROBIN(1), .READ_LATENCY(1)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_addr(addr),
        .i_req_wdata(wdata), .i_req_byte_en(be), .i_req_read(read), .i_req_lock(lock),
        .o_req_ready(rdy_r), .i_stall(stall), .o_data_mem_addr(maddr_r),
        .o_data_mem_wr_data(mwd_r), .o_data_mem_per_byte_wr_en(mbe_r),
        .o_data_mem_read_enable(mre_r), .i_data_mem_rd_data(rd_data),
        .o_rsp_valid(rspv_r), .o_rsp_data(rspd_r), .o_lock_active(lka_r), .o_lock_owner(lko_r));

    data_mem_port_arbiter #(.NUM_PORTS(4), .ROUND_ROBIN(0), .READ_LATENCY(2)) u_lat2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_addr(addr),
        .i_req_wdata(wdata), .i_req_byte_en(be), .i_req_read(read), .i_req_lock(lock),
        .o_req_ready(rdy_l), .i_stall(stall), .o_data_mem_addr(maddr_l),
        .o_data_mem_wr_data(mwd_l), .o_data_mem_per_byte_wr_en(mbe_l),
        .o_data_mem_read_enable(mre_l), .i_data_mem_rd_data(rd_data),
        .o_rsp_valid(rspv_l), .o_rsp_data(rspd_l), .o_lock_active(lka_l), .o_lock_owner(lko_l));

    task automatic clear_inputs();
        valid   = '0;
        read    = '0;
        lock    = '0;
        be      = '0;
        stall   = 1'b0;
        rd_data = '0;
        for (int p = 0; p < 4; p++) begin
            addr[p]  = 32'h1000 + 32'(p * 16);
            wdata[p] = 32'hA0 + 32'(p);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        valid = 4'hF;
        read  = 4'hF;
        @(negedge clk);
        #1;
        checks++; if (rdy_f !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", rdy_f); end
        checks++; if (mre_f !== 1'b0) begin errors++; $display("FAIL rst_read_en got=%b exp=0", mre_f); end
        checks++; if (lka_f !== 1'b0) begin errors++; $display("FAIL rst_lock_active got=%b exp=0", lka_f); end
        checks++; if (lko_f !== 2'd0) begin errors++; $display("FAIL rst_lock_owner got=%0d exp=0", lko_f); end
        checks++; if (rspv_f !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0000", rspv_f); end
        checks++; if (rdy_r !== 4'b0000) begin errors++; $display("FAIL rst_rr_ready got=%b exp=0000", rdy_r); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        valid = 4'hF;
        read  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rdy_f !== 4'b0001) begin errors++; $display("FAIL fix_grant%0d got=%b exp=0001", k, rdy_f); end
            checks++; if (maddr_f !== 32'h1000) begin errors++; $display("FAIL fix_addr%0d got=%h exp=00001000", k, maddr_f); end
            if (k > 0) begin
                checks++; if (rspv_f !== 4'b0001) begin errors++; $display("FAIL fix_rsp%0d got=%b exp=0001", k, rspv_f); end
            end
            @(negedge clk);
        end
        valid = 4'b1110;
        #1;
        checks++; if (rdy_f !== 4'b0010) begin errors++; $display("FAIL fix_after_drop got=%b exp=0010", rdy_f); end
        checks++; if (maddr_f !== 32'h1010) begin errors++; $display("FAIL fix_after_drop_addr got=%h exp=00001010", maddr_f); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0]  seq [5];
        logic [31:0] exp_addr [5];
        seq      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_addr = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1000};
        apply_reset();
        valid = 4'hF;
        read  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (rdy_r !== seq[k]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, rdy_r, seq[k]); end
            checks++; if (maddr_r !== exp_addr[k]) begin errors++; $display("FAIL rr_addr%0d got=%h exp=%h", k, maddr_r, exp_addr[k]); end
            if (k > 0) begin
                checks++; if (rspv_r !== seq[k-1]) begin errors++; $display("FAIL rr_rsp%0d got=%b exp=%b", k, rspv_r, seq[k-1]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock_amo();
        apply_reset();
        valid   = 4'b0100;
        read[2] = 1'b1;
        lock[2] = 1'b1;
        addr[2] = 32'h0000_00FC;
        #1;
        checks++; if (rdy_f !== 4'b0100) begin errors++; $display("FAIL amo_first_grant got=%b exp=0100", rdy_f); end
        checks++; if (lka_f !== 1'b0) begin errors++; $display("FAIL amo_first_lock got=%b exp=0", lka_f); end
        @(negedge clk);
        valid   = 4'b0101;
        read[0] = 1'b1;
        addr[2] = 32'h0000_0100;
        #1;
        checks++; if (rdy_f !== 4'b0100) begin errors++; $display("FAIL amo_read_grant got=%b exp=0100", rdy_f); end
        checks++; if (lka_f !== 1'b1 || lko_f !== 2'd2) begin errors++; $display("FAIL amo_read_lock got=%b/%0d exp=1/2", lka_f, lko_f); end
        checks++; if (mre_f !== 1'b1 || maddr_f !== 32'h100) begin errors++; $display("FAIL amo_read_bus got=%b/%h exp=1/00000100", mre_f, maddr_f); end
        checks++; if (rspv_f !== 4'b0100) begin errors++; $display("FAIL amo_rsp_first got=%b exp=0100", rspv_f); end
        @(negedge clk);
        read[2]  = 1'b0;
        lock[2]  = 1'b0;
        be[2]    = 4'hF;
        wdata[2] = 32'hDEAD_BEEF;
        rd_data  = 32'h1234_5678;
        #1;
        checks++; if (rdy_f !== 4'b0100) begin errors++; $display("FAIL amo_write_grant got=%b exp=0100", rdy_f); end
        checks++; if (mbe_f !== 4'hF) begin errors++; $display("FAIL amo_write_be got=%b exp=1111", mbe_f); end
        checks++; if (mwd_f !== 32'hDEAD_BEEF) begin errors++; $display("FAIL amo_write_data got=%h exp=deadbeef", mwd_f); end
        checks++; if (mre_f !== 1'b0) begin errors++; $display("FAIL amo_write_read_en got=%b exp=0", mre_f); end
        checks++; if (rspv_f !== 4'b0100 || rspd_f !== 32'h1234_5678) begin errors++; $display("FAIL amo_read_rsp got=%b/%h exp=0100/12345678", rspv_f, rspd_f); end
        @(negedge clk);
        valid = 4'b0001;
        #1;
        checks++; if (rdy_f !== 4'b0001) begin errors++; $display("FAIL amo_release_grant got=%b exp=0001", rdy_f); end
        checks++; if (lka_f !== 1'b0) begin errors++; $display("FAIL amo_release_lock got=%b exp=0", lka_f); end
        checks++; if (rspv_f !== 4'b0000) begin errors++; $display("FAIL amo_write_no_rsp got=%b exp=0000", rspv_f); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [3:0] exp_f, exp_l;
        apply_reset();
        valid = 4'b0010;
        read  = 4'b0010;
        #1;
        checks++; if (rdy_f !== 4'b0010 || mre_f !== 1'b1) begin errors++; $display("FAIL stall_pre got=%b/%b exp=0010/1", rdy_f, mre_f); end
        @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_f = (k == 0) ? 4'b0010 : 4'b0000;
            exp_l = (k == 1) ? 4'b0010 : 4'b0000;
            #1;
            checks++; if (rdy_f !== 4'b0000 || rdy_l !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d got=%b/%b exp=0000/0000", k, rdy_f, rdy_l); end
            checks++; if (mre_f !== 1'b0 || mbe_f !== 4'b0000) begin errors++; $display("FAIL stall_enables%0d got=%b/%b exp=0/0000", k, mre_f, mbe_f); end
            checks++; if (rspv_f !== exp_f) begin errors++; $display("FAIL stall_rsp_fix%0d got=%b exp=%b", k, rspv_f, exp_f); end
            checks++; if (rspv_l !== exp_l) begin errors++; $display("FAIL stall_rsp_lat2_%0d got=%b exp=%b", k, rspv_l, exp_l); end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        checks++; if (rdy_f !== 4'b0010) begin errors++; $display("FAIL stall_resume got=%b exp=0010", rdy_f); end
        @(negedge clk);
    endtask

    task automatic test_write_wins();
        apply_reset();
        valid = 4'b0001;
        read  = 4'b0001;
        be[0] = 4'b0011;
        #1;
        checks++; if (mbe_f !== 4'b0011 || mre_f !== 1'b0) begin errors++; $display("FAIL wr_wins_bus got=%b/%b exp=0011/0", mbe_f, mre_f); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (rspv_f !== 4'b0000) begin errors++; $display("FAIL wr_wins_no_rsp got=%b exp=0000", rspv_f); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_lock();
        apply_reset();
        valid = 4'b1000;
        read  = 4'b1000;
        lock  = 4'b1000;
        #1;
        checks++; if (rdy_f !== 4'b1000) begin errors++; $display("FAIL midrst_grant got=%b exp=1000", rdy_f); end
        @(negedge clk);
        valid = 4'b0000;
        #1;
        checks++; if (lka_f !== 1'b1 || lko_f !== 2'd3) begin errors++; $display("FAIL midrst_locked got=%b/%0d exp=1/3", lka_f, lko_f); end
        checks++; if (rspv_f !== 4'b1000) begin errors++; $display("FAIL midrst_inflight got=%b exp=1000", rspv_f); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (lka_f !== 1'b0 || lko_f !== 2'd0) begin errors++; $display("FAIL midrst_lock_clear got=%b/%0d exp=0/0", lka_f, lko_f); end
        checks++; if (rspv_f !== 4'b0000) begin errors++; $display("FAIL midrst_rsp_clear got=%b exp=0000", rspv_f); end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 4'b1001;
        read  = 4'b1001;
        lock  = 4'b0000;
        #1;
        checks++; if (rdy_f !== 4'b0001) begin errors++; $display("FAIL midrst_after got=%b exp=0001", rdy_f); end
        @(negedge clk);
    endtask

    task automatic test_latency2();
        apply_reset();
        valid   = 4'b0010;
        read    = 4'b0010;
        addr[1] = 32'h200;
        #1;
        checks++; if (rdy_l !== 4'b0010 || mre_l !== 1'b1 || maddr_l !== 32'h200) begin errors++; $display("FAIL lat2_rd1 got=%b/%b/%h exp=0010/1/00000200", rdy_l, mre_l, maddr_l); end
        @(negedge clk);
        valid   = 4'b1000;
        read    = 4'b1000;
        addr[3] = 32'h300;
        #1;
        checks++; if (rdy_l !== 4'b1000 || maddr_l !== 32'h300) begin errors++; $display("FAIL lat2_rd3 got=%b/%h exp=1000/00000300", rdy_l, maddr_l); end
        checks++; if (rspv_l !== 4'b0000) begin errors++; $display("FAIL lat2_early got=%b exp=0000", rspv_l); end
        @(negedge clk);
        clear_inputs();
        rd_data = 32'h1111_1111;
        #1;
        checks++; if (rspv_l !== 4'b0010 || rspd_l !== 32'h1111_1111) begin errors++; $display("FAIL lat2_rsp1 got=%b/%h exp=0010/11111111", rspv_l, rspd_l); end
        @(negedge clk);
        rd_data = 32'h3333_3333;
        #1;
        checks++; if (rspv_l !== 4'b1000 || rspd_l !== 32'h3333_3333) begin errors++; $display("FAIL lat2_rsp3 got=%b/%h exp=1000/33333333", rspv_l, rspd_l); end
        @(negedge clk);
        #1;
        checks++; if (rspv_l !== 4'b0000) begin errors++; $display("FAIL lat2_done got=%b exp=0000", rspv_l); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock_amo();
        test_stall();
        test_write_wins();
        test_reset_mid_lock();
        test_latency2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
